// File: rtl/serial_frame_tx.sv
// serial_frame_tx: serial frame transmitter (1s preamble, MSB-first payload, 0s gap)
// Ports:
//   clk, reset        clock and synchronous active-high reset
//   start, data       frame request and payload, captured when ready=1
//   abort             cut a frame short in PRE/DATA; the gap still runs in full
//   ready, busy       IDLE vs PRE/DATA/GAP
//   x_out             serial line
//   done              one-cycle pulse on the final gap cycle
//   st_idle..st_gap   one-hot state decode
module serial_frame_tx #(
  parameter int WIDTH   = 8,
  parameter int PRE_LEN = 2,
  parameter int GAP_LEN = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] data,
  input  logic             abort,
  output logic             ready,
  output logic             x_out,
  output logic             busy,
  output logic             done,
  output logic             st_idle,
  output logic             st_pre,
  output logic             st_data,
  output logic             st_gap
);
  localparam int MAXL = (PRE_LEN > WIDTH ? (PRE_LEN > GAP_LEN ? PRE_LEN : GAP_LEN)
                                         : (WIDTH > GAP_LEN ? WIDTH : GAP_LEN));
  localparam int CW = $clog2(MAXL) + 1;
  localparam logic [CW-1:0] PRE_LAST  = CW'(PRE_LEN - 1);
  localparam logic [CW-1:0] DATA_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_LEN - 1);

  typedef enum logic [1:0] {S_IDLE, S_PRE, S_DATA, S_GAP} state_t;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_shreg, w_shreg_nxt;
  logic [CW-1:0]    r_cnt, w_cnt_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_shreg <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_shreg <= w_shreg_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_shreg_nxt = r_shreg;
    w_cnt_nxt   = r_cnt + CW'(1);
    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        if (start) begin
          w_state_nxt = S_PRE;
          w_shreg_nxt = data;
        end
      end
      S_PRE: begin
        if (abort || r_cnt == PRE_LAST) begin
          w_state_nxt = abort ? S_GAP : S_DATA;
          w_cnt_nxt   = '0;
        end
      end
      S_DATA: begin
        w_shreg_nxt = r_shreg << 1;
        if (abort || r_cnt == DATA_LAST) begin
          w_state_nxt = S_GAP;
          w_cnt_nxt   = '0;
        end
      end
      default: begin
        if (r_cnt == GAP_LAST) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end
      end
    endcase
  end

  assign st_idle = (r_state == S_IDLE);
  assign st_pre  = (r_state == S_PRE);
  assign st_data = (r_state == S_DATA);
  assign st_gap  = (r_state == S_GAP);
  assign ready   = st_idle;
  assign busy    = ~st_idle;
  assign x_out   = st_pre | (st_data & r_shreg[WIDTH-1]);
  assign done    = st_gap & (r_cnt == GAP_LAST);
endmodule
